// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - parallel-to-serial stimulus generator, MSB first, with bit stretch and word gap
//
// Purpose:
//   Accepts WIDTH-bit words over a valid/ready handshake and serializes them
//   MSB-first onto serial_out. Each bit is held BIT_CYCLES cycles, and every
//   word is followed by GAP_CYCLES cycles of IDLE_LEVEL.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   load_valid   upstream word available on load_data
//   load_data    word to serialize, captured on accept
//   load_ready   block can accept a word this cycle (combinational)
//   serial_out   registered serial bit stream
//   serial_valid registered, high while serial_out carries a data bit
//   word_done    registered, high during the final cycle of the LSB
//   busy         registered, high whenever not IDLE
module serial_pattern_gen #(
  parameter int   WIDTH      = 8,
  parameter int   BIT_CYCLES = 1,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int MAXC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(WIDTH);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic serial_out_q, serial_out_d;
  logic serial_valid_q, serial_valid_d;
  logic word_done_q, word_done_d;
  logic busy_q, busy_d;

  logic last_shift_cycle;
  logic last_gap_cycle;
  logic accept;

  assign last_shift_cycle = (state_q == S_SHIFT) && (bit_idx_q == '0) && (cnt_q == BIT_LAST);
  assign last_gap_cycle   = (state_q == S_GAP) && (cnt_q == GAP_LAST);

  // Ready opens in the final cycle of a frame so the next word follows with no bubble.
  assign load_ready = (state_q == S_IDLE) ||
                      (HAS_GAP ? last_gap_cycle : last_shift_cycle);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_SHIFT;
          shreg_d   = load_data;
          bit_idx_d = IDX_TOP;
          cnt_d     = '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == '0) begin
            // End of word: the state transition wins, the index never wraps.
            if (HAS_GAP) begin
              state_d = S_GAP;
            end else if (accept) begin
              state_d   = S_SHIFT;
              shreg_d   = load_data;
              bit_idx_d = IDX_TOP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q - IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (accept) begin
            state_d   = S_SHIFT;
            shreg_d   = load_data;
            bit_idx_d = IDX_TOP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from next-state so the registered copy lines up
  // with the cycle it describes.
  always_comb begin
    serial_valid_d = (state_d == S_SHIFT);
    serial_out_d   = (state_d == S_SHIFT) ? shreg_d[bit_idx_d] : IDLE_LEVEL;
    word_done_d    = (state_d == S_SHIFT) && (bit_idx_d == '0) && (cnt_d == BIT_LAST);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      bit_idx_q      <= '0;
      cnt_q          <= '0;
      serial_out_q   <= IDLE_LEVEL;
      serial_valid_q <= 1'b0;
      word_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_idx_q      <= bit_idx_d;
      cnt_q          <= cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      word_done_q    <= word_done_d;
      busy_q         <= busy_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign word_done    = word_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - directed self-checking bench for serial_pattern_gen
module tb_serial_pattern_gen;

  logic clock = 1'b0;
  logic reset;

  logic       lv0, lv1, lv2;
  logic [7:0] ld0, ld1, ld2;
  logic       rdy0, out0, val0, wd0, busy0;
  logic       rdy1, out1, val1, wd1, busy1;
  logic       rdy2, out2, val2, wd2, busy2;

  int checks = 0;
  int errors = 0;
  int sel;
  logic [4:0] obs;  // {out, valid, word_done, ready, busy} of the selected instance

  always #5 clock = ~clock;

  serial_pattern_gen #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut (
    .clock(clock), .reset(reset), .load_valid(lv0), .load_data(ld0), .load_ready(rdy0),
    .serial_out(out0), .serial_valid(val0), .word_done(wd0), .busy(busy0)
  );

  serial_pattern_gen #(.WIDTH(8), .BIT_CYCLES(3), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut_s (
    .clock(clock), .reset(reset), .load_valid(lv1), .load_data(ld1), .load_ready(rdy1),
    .serial_out(out1), .serial_valid(val1), .word_done(wd1), .busy(busy1)
  );

  serial_pattern_gen #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut_z (
    .clock(clock), .reset(reset), .load_valid(lv2), .load_data(ld2), .load_ready(rdy2),
    .serial_out(out2), .serial_valid(val2), .word_done(wd2), .busy(busy2)
  );

  always_comb begin
    case (sel)
      1:       obs = {out1, val1, wd1, rdy1, busy1};
      2:       obs = {out2, val2, wd2, rdy2, busy2};
      default: obs = {out0, val0, wd0, rdy0, busy0};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cyc(input string tag, input int k, input logic eo, input logic ev,
                           input logic ew, input logic er, input logic eb);
    check($sformatf("%s[%0d].out", tag, k),   32'(obs[4]), 32'(eo));
    check($sformatf("%s[%0d].valid", tag, k), 32'(obs[3]), 32'(ev));
    check($sformatf("%s[%0d].done", tag, k),  32'(obs[2]), 32'(ew));
    check($sformatf("%s[%0d].ready", tag, k), 32'(obs[1]), 32'(er));
    check($sformatf("%s[%0d].busy", tag, k),  32'(obs[0]), 32'(eb));
  endtask

  logic [7:0]  pat;
  logic [15:0] w16;

  initial begin
    reset = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    ld0 = '0;   ld1 = '0;   ld2 = '0;
    sel = 0;

    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_cyc($sformatf("reset%0d", s), 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single word 1011_0010, gap 2
    sel = 0;
    lv0 = 1'b1; ld0 = 8'hB2;
    @(negedge clock);
    lv0 = 1'b0;
    pat = 8'hB2;
    for (int k = 1; k <= 11; k++) begin
      check_cyc("single", k, (k <= 8) ? pat[8-k] : 1'b0, k <= 8, k == 8, k >= 10, k <= 10);
      @(negedge clock);
    end

    // Back-to-back FF then 00 with load_valid held; data changes after first accept
    lv0 = 1'b1; ld0 = 8'hFF;
    @(negedge clock);
    ld0 = 8'h00;
    for (int k = 1; k <= 21; k++) begin
      if (k == 11) lv0 = 1'b0;
      check_cyc("b2b", k, k <= 8, (k <= 8) || (k >= 11 && k <= 18),
                (k == 8) || (k == 18), (k == 10) || (k >= 20), k <= 20);
      @(negedge clock);
    end

    // load_valid pulsed mid-frame with 55 must be ignored
    lv0 = 1'b1; ld0 = 8'hC3;
    @(negedge clock);
    lv0 = 1'b0;
    pat = 8'hC3;
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) begin lv0 = 1'b1; ld0 = 8'h55; end
      if (k == 4) lv0 = 1'b0;
      check_cyc("ignore", k, (k <= 8) ? pat[8-k] : 1'b0, k <= 8, k == 8, k >= 10, k <= 10);
      @(negedge clock);
    end

    // Bit stretch: BIT_CYCLES=3, A5 -> 111000111000000111000111
    sel = 1;
    lv1 = 1'b1; ld1 = 8'hA5;
    @(negedge clock);
    lv1 = 1'b0;
    pat = 8'hA5;
    for (int k = 1; k <= 27; k++) begin
      check_cyc("stretch", k, (k <= 24) ? pat[7-(k-1)/3] : 1'b0, k <= 24, k == 24, k >= 26, k <= 26);
      @(negedge clock);
    end

    // GAP=0 streaming F0 then 0F with no bubble
    sel = 2;
    lv2 = 1'b1; ld2 = 8'hF0;
    @(negedge clock);
    ld2 = 8'h0F;
    w16 = 16'hF00F;
    for (int k = 1; k <= 17; k++) begin
      if (k == 9) lv2 = 1'b0;
      check_cyc("gap0", k, (k <= 16) ? w16[16-k] : 1'b0, k <= 16,
                (k == 8) || (k == 16), (k == 8) || (k >= 16), k <= 16);
      @(negedge clock);
    end

    // Asynchronous reset in cycle 5 of a 9C frame
    sel = 0;
    lv0 = 1'b1; ld0 = 8'h9C;
    @(negedge clock);
    lv0 = 1'b0;
    pat = 8'h9C;
    for (int k = 1; k <= 5; k++) begin
      check_cyc("prerst", k, pat[8-k], 1'b1, 1'b0, 1'b0, 1'b1);
      if (k < 5) @(negedge clock);
    end
    #1 reset = 1'b1;
    #1;
    check_cyc("asyncrst", 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    check_cyc("release", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lv0 = 1'b1; ld0 = 8'h80;
    @(negedge clock);
    lv0 = 1'b0;
    pat = 8'h80;
    for (int k = 1; k <= 11; k++) begin
      check_cyc("postrst", k, (k <= 8) ? pat[8-k] : 1'b0, k <= 8, k == 8, k >= 10, k <= 10);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Upstream stimulus stage for the serial sequence-detector FSM.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first into the single-bit stream that drives the FSM's `In` input.
- Supports configurable bit period and inter-word gap, so lab benches can drive the detector with framed, repeatable bit patterns instead of hand-timed stimulus.

Parameters:
- WIDTH, 8: word width in bits; legal range ≥ 2.
- BIT_CYCLES, 1: clock cycles each bit is held on serial_out; legal range ≥ 1.
- GAP_CYCLES, 2: cycles of idle level inserted after each word; legal range ≥ 0.
- IDLE_LEVEL, 1'b0: serial_out value whenever no bit is being driven.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream has a word on load_data.
- load_data  input  WIDTH  word to serialize; sampled only on accept.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial bit stream; connects to the FSM's `In`.
- serial_valid  output  1  high while serial_out carries a data bit.
- word_done  output  1  one-cycle pulse during the final cycle of the LSB.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - Single clock domain: `clock`.
  - `reset` is asynchronous and active-high. While it is high, all outputs take their reset values immediately, with no clock edge needed.
- Reset values:
  - State = IDLE; shift register = 0; counters = 0.
  - serial_out = IDLE_LEVEL; serial_valid = 0; word_done = 0; busy = 0; load_ready = 1.
- States: IDLE, SHIFT, GAP.
- Handshake:
  - A word is accepted on a rising edge where load_valid && load_ready.
  - load_data is captured into the shift register on that edge.
  - Later changes to load_data have no effect on the word in flight.
  - load_valid while load_ready = 0 is ignored; nothing is captured and there is no error.
- load_ready is high:
  - in IDLE;
  - in the last GAP cycle when GAP_CYCLES > 0;
  - in the last cycle of the LSB when GAP_CYCLES = 0.
  - It is low at all other times.
- IDLE:
  - serial_out = IDLE_LEVEL; serial_valid = 0.
  - On accept, go to SHIFT.
- SHIFT:
  - The first cycle after accept drives bit WIDTH-1; latency from accept edge to first bit is 1 cycle.
  - Each bit is held for exactly BIT_CYCLES cycles, then the next lower bit follows.
  - serial_valid = 1 throughout SHIFT.
  - Total SHIFT duration is WIDTH*BIT_CYCLES cycles.
  - word_done = 1 for exactly the final SHIFT cycle.
  - After the last cycle, go to GAP if GAP_CYCLES > 0.
  - If GAP_CYCLES = 0: go to SHIFT again if a new word is accepted in that cycle, otherwise go to IDLE.
- GAP:
  - serial_out = IDLE_LEVEL; serial_valid = 0 for GAP_CYCLES cycles.
  - At the end of the last GAP cycle: go to SHIFT if a word was accepted, otherwise go to IDLE.
- Back-to-back words: an accept in a load_ready cycle inside an active frame produces no extra bubble. The next word's MSB appears on the cycle immediately after that load_ready cycle.
- Counters:
  - The bit index counter counts down from WIDTH-1 to 0 and is $clog2(WIDTH) bits wide.
  - The cycle counter is wide enough for max(BIT_CYCLES, GAP_CYCLES) and reloads to 0 at each bit or phase boundary.
  - There is no wrap-around past bit 0: the state transition takes precedence.
- Registered outputs: serial_out, serial_valid, word_done and busy are registered, so no glitches reach the FSM. load_ready is combinational from state and counters.
- Reset mid-operation:
  - The in-flight word is discarded and no word_done pulse is produced.
  - After release, the block is in IDLE and can accept on the first edge.
- Simultaneous events: reset overrides everything; accept and word_done in the same cycle are legal (GAP_CYCLES = 0 back-to-back).

Test Plan:
- Single word: WIDTH=8, BIT_CYCLES=1, GAP=2; accept 8'b1011_0010 at edge 0.
  - serial_out = 1,0,1,1,0,0,1,0 in cycles 1–8, with serial_valid = 1 in cycles 1–8.
  - word_done in cycle 8 only; serial_out = 0 and serial_valid = 0 in cycles 9–10.
  - load_ready high in cycle 10; IDLE in cycle 11.
- Back-to-back: hold load_valid with 8'hFF then 8'h00 (GAP=2).
  - Second accept occurs at cycle 10; its MSB 0 appears in cycle 11.
  - Exactly one word_done per word; load_ready is low during cycles 1–9.
- Bit stretch: BIT_CYCLES=3, word 8'hA5.
  - Each bit is held 3 cycles; the pattern is 111000111000000111000111.
  - word_done occurs in cycle 24.
- Reset mid-word: assert reset asynchronously between edges 4 and 5.
  - serial_out goes to 0 and busy to 0 before the next edge.
  - No word_done is produced; after release the first edge with load_valid accepts.
- GAP=0 streaming: two words 8'hF0 and 8'h0F.
  - Continuous 16-bit stream 1111000000001111 with no bubble.
  - word_done in cycles 8 and 16; load_ready high in cycle 8.
- Busy-ignore: pulse load_valid with 8'h55 during cycle 3 of a frame.
  - No capture occurs; the stream of the current word is unchanged.
